// File: rtl/iqmap_pkg.sv
// Shared types and constants for the IQ-mapper sequencer.
package iqmap_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, DRAIN} state_t;

  localparam logic MOD_QPSK  = 1'b0;
  localparam logic MOD_16QAM = 1'b1;

  // Mapped symbols produced from one 128-bit word.
  function automatic logic [6:0] SYMS_PER_WORD(input logic mod);
    return (mod == MOD_16QAM) ? 7'd32 : 7'd64;
  endfunction

endpackage

// File: rtl/iqmap_ctrl_if.sv
// FIFO-side and mapper-side handshake bundle of the IQ-mapper sequencer.
interface iqmap_ctrl_if #(parameter int WORD_W = 128);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [WORD_W-1:0] fifo_dout;
  logic              map_ready;
  logic              map_valid;
  logic [WORD_W-1:0] map_data;
  logic              map_sym_valid;

  modport master (
    input  fifo_empty, fifo_dout, map_ready, map_sym_valid,
    output fifo_rd_en, map_valid, map_data
  );

  modport slave (
    output fifo_empty, fifo_dout, map_ready, map_sym_valid,
    input  fifo_rd_en, map_valid, map_data
  );
endinterface

// File: rtl/iqmap_carrier_cnt.sv
// Carrier position within the OFDM symbol; flags first/last carrier one cycle
// after the mapper symbol and counts completed OFDM symbols.
module iqmap_carrier_cnt #(
  parameter int SYMS_PER_OFDM = 96,
  parameter int CW            = $clog2(SYMS_PER_OFDM)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          sym_valid,
  output logic [CW-1:0] carrier,
  output logic          sym_first,
  output logic          sym_last,
  output logic [7:0]    ofdm_cnt
);

  localparam logic [CW-1:0] LAST = CW'(SYMS_PER_OFDM - 1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      carrier   <= '0;
      sym_first <= 1'b0;
      sym_last  <= 1'b0;
      ofdm_cnt  <= '0;
    end else begin
      sym_first <= 1'b0;
      sym_last  <= 1'b0;
      if (sym_valid) begin
        sym_first <= (carrier == '0);
        sym_last  <= (carrier == LAST);
        if (carrier == LAST) begin
          carrier  <= '0;
          ofdm_cnt <= ofdm_cnt + 8'd1;
        end else begin
          carrier <= carrier + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iqmap_ctrl.sv
// Fetches words from the bit-stream FIFO, hands them to the IQ mapper one at a
// time and tracks mapped carriers / OFDM-symbol boundaries.
module iqmap_ctrl
  import iqmap_pkg::*;
#(
  parameter int WORD_W        = 128,
  parameter int SYMS_PER_OFDM = 96,
  parameter int RD_LAT        = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ce,
  input  logic         mod_sel,
  iqmap_ctrl_if.master bus,
  output logic         sym_first,
  output logic         sym_last,
  output logic [7:0]   ofdm_cnt,
  output logic         mod_cur,
  output logic         busy,
  output logic         underrun
);

  localparam int         CW  = $clog2(SYMS_PER_OFDM);
  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t            state, state_nxt;
  logic              rd_en_q;
  logic [1:0]        lat_cnt;
  logic              captured;
  logic [WORD_W-1:0] word_q;
  logic [6:0]        drain_cnt;
  logic              drain_done;
  logic [CW-1:0]     carrier;
  logic              go;

  assign go         = ce & bus.map_ready & ~bus.fifo_empty;
  assign drain_done = (drain_cnt == SYMS_PER_WORD(mod_cur));

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.map_valid  = (state == LOAD) & ce;
  assign bus.map_data   = word_q;
  assign busy           = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (go) state_nxt = FETCH;
      FETCH: if (lat_cnt == LAT && ce) state_nxt = LOAD;
      LOAD:  if (ce) state_nxt = DRAIN;
      DRAIN: if (ce && drain_done && bus.map_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rd_en_q   <= 1'b0;
      lat_cnt   <= '0;
      captured  <= 1'b0;
      word_q    <= '0;
      drain_cnt <= '0;
      mod_cur   <= MOD_QPSK;
      underrun  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_en_q <= (state == IDLE) && go;

      // Read latency runs even with ce low so an issued read always lands;
      // the word is taken exactly once while FETCH waits for ce.
      if (state == FETCH) begin
        if (lat_cnt != LAT) lat_cnt <= lat_cnt + 2'd1;
        if (lat_cnt == LAT && !captured) begin
          word_q   <= bus.fifo_dout;
          captured <= 1'b1;
        end
      end else begin
        lat_cnt  <= '0;
        captured <= 1'b0;
      end

      if (state == LOAD)
        drain_cnt <= '0;
      else if (state == DRAIN && bus.map_sym_valid && !drain_done)
        drain_cnt <= drain_cnt + 7'd1;

      // Mode only switches on an OFDM-symbol boundary.
      if (state == IDLE && carrier == '0)
        mod_cur <= mod_sel;

      if (state == IDLE && ce && bus.map_ready && bus.fifo_empty && carrier != '0)
        underrun <= 1'b1;
    end
  end

  iqmap_carrier_cnt #(.SYMS_PER_OFDM(SYMS_PER_OFDM), .CW(CW)) u_carrier (
    .CLK       (CLK),
    .RST       (RST),
    .sym_valid (bus.map_sym_valid),
    .carrier   (carrier),
    .sym_first (sym_first),
    .sym_last  (sym_last),
    .ofdm_cnt  (ofdm_cnt)
  );

endmodule
